// File: rtl/divide_arbiter.sv
// divide_arbiter: round-robin share of one combinational divider among 4 ports (req/operand buses in; grant/done/done_id/busy strobes and registered quotient/remainder/zeroflag out)
module serial_divide_uu #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);
  logic [SIZE:0] t;
  always_comb begin
    t = '0;
    quotient = '0;
    remainder = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      t = {remainder, dividend[i]};
      quotient[i] = t >= {1'b0, divisor};
      remainder = quotient[i] ? SIZE'(t - {1'b0, divisor}) : t[SIZE-1:0];
    end
  end
  assign div_by_zero = divisor == '0;
endmodule

module divide_arbiter #(
  parameter int SIZE = 16,
  parameter int CALC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [4*SIZE-1:0] dividend_bus,
  input  logic [4*SIZE-1:0] divisor_bus,
  output logic [3:0]        grant,
  output logic [3:0]        done,
  output logic [1:0]        done_id,
  output logic              busy,
  output logic [SIZE-1:0]   quotient,
  output logic [SIZE-1:0]   remainder,
  output logic              zeroflag
);
  localparam int CW = CALC_CYCLES > 1 ? $clog2(CALC_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [1:0] ptr, win;
  logic [CW-1:0] cnt;
  logic [SIZE-1:0] op_a, op_b, d_q, d_r;
  logic d_z;
  serial_divide_uu #(.SIZE(SIZE)) u_div (
    .dividend(op_a),
    .divisor(op_b),
    .quotient(d_q),
    .remainder(d_r),
    .div_by_zero(d_z)
  );
  // scan from the highest offset down so the port closest to ptr wins
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--) win = req[ptr + 2'(k)] ? ptr + 2'(k) : win;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      grant <= '0;
      done <= '0;
      done_id <= '0;
      quotient <= '0;
      remainder <= '0;
      zeroflag <= '0;
      op_a <= '0;
      op_b <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          op_a <= dividend_bus[win*SIZE +: SIZE];
          op_b <= divisor_bus[win*SIZE +: SIZE];
          done_id <= win;
          grant <= 4'b1 << win;
          cnt <= CW'(CALC_CYCLES - 1);
          state <= CALC;
        end
        CALC: begin
          grant <= '0;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            quotient <= d_z ? '1 : d_q;
            remainder <= d_z ? op_a : d_r;
            zeroflag <= d_z;
            done <= 4'b1 << done_id;
            ptr <= done_id + 2'd1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divide_arbiter.sv
// tb_divide_arbiter: directed checks of arbitration order, timing, divide results and async reset
module tb_divide_arbiter;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [4*W-1:0] dividend_bus = '0;
  logic [4*W-1:0] divisor_bus = '0;
  logic [3:0] grant, done;
  logic [1:0] done_id;
  logic busy, zeroflag;
  logic [W-1:0] quotient, remainder;
  int passed = 0;
  int total = 0;
  int fails = 0;
  logic [15:0] all_a [4] = '{16'd1000, 16'd777, 16'd60000, 16'd9};
  logic [15:0] all_b [4] = '{16'd10, 16'd5, 16'd123, 16'd20};
  logic [15:0] all_q [4] = '{16'd100, 16'd155, 16'd487, 16'd0};
  logic [15:0] all_r [4] = '{16'd0, 16'd2, 16'd99, 16'd9};
  divide_arbiter #(.SIZE(W), .CALC_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .dividend_bus(dividend_bus),
    .divisor_bus(divisor_bus),
    .grant(grant),
    .done(done),
    .done_id(done_id),
    .busy(busy),
    .quotient(quotient),
    .remainder(remainder),
    .zeroflag(zeroflag)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_ops(input int p, input logic [15:0] a, input logic [15:0] b);
    dividend_bus[p*W +: W] = a;
    divisor_bus[p*W +: W] = b;
  endtask
  // req for port p must already be high in the current IDLE cycle
  task automatic run_held(input int p, input logic [15:0] eq, input logic [15:0] er, input logic ez);
    tick();
    chk("grant", 32'(grant), 32'(1) << p);
    chk("busy_grant", 32'(busy), 1);
    chk("done_id", 32'(done_id), 32'(p));
    tick();
    chk("grant_clear", 32'(grant), 0);
    chk("done_early", 32'(done), 0);
    tick();
    chk("done", 32'(done), 32'(1) << p);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("zeroflag", 32'(zeroflag), 32'(ez));
    req[p] = 1'b0;
    tick();
    chk("done_drop", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask
  task automatic serve(input int p, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic ez);
    set_ops(p, a, b);
    req[p] = 1'b1;
    run_held(p, eq, er, ez);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_zeroflag", 32'(zeroflag), 0);
    reset = 1'b0;
    tick();
    serve(1, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    chk("hold_quotient", 32'(quotient), 14);
    serve(2, 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
    serve(0, 16'd65535, 16'd255, 16'd257, 16'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < 4; p++) set_ops(p, all_a[p], all_b[p]);
    req = 4'b1111;
    for (int p = 0; p < 4; p++) run_held(p, all_q[p], all_r[p], 1'b0);
    set_ops(0, 16'd500, 16'd7);
    set_ops(2, 16'd40, 16'd6);
    req = 4'b0101;
    run_held(0, 16'd71, 16'd3, 1'b0);
    run_held(2, 16'd6, 16'd4, 1'b0);
    set_ops(1, 16'd100, 16'd7);
    set_ops(3, 16'd9, 16'd20);
    req = 4'b0010;
    tick();
    chk("mid_grant", 32'(grant), 32'b0010);
    req[3] = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_done_id", 32'(done_id), 0);
    chk("async_quotient", 32'(quotient), 0);
    chk("async_remainder", 32'(remainder), 0);
    tick();
    chk("async_done", 32'(done), 0);
    reset = 1'b0;
    req[3] = 1'b1;
    tick();
    chk("regrant", 32'(grant), 32'b0010);
    tick();
    tick();
    chk("regrant_done", 32'(done), 32'b0010);
    chk("regrant_q", 32'(quotient), 14);
    chk("regrant_r", 32'(remainder), 2);
    req = 4'b0000;
    tick();
    chk("regrant_idle", 32'(busy), 0);
    set_ops(0, 16'd1000, 16'd10);
    req[0] = 1'b1;
    tick();
    chk("hold1_grant", 32'(grant), 32'b0001);
    tick();
    tick();
    chk("hold1_done", 32'(done), 32'b0001);
    chk("hold1_q", 32'(quotient), 100);
    set_ops(0, 16'd50000, 16'd3);
    tick();
    chk("hold_idle_busy", 32'(busy), 0);
    chk("hold_idle_grant", 32'(grant), 0);
    chk("hold_idle_q", 32'(quotient), 100);
    run_held(0, 16'd16666, 16'd2, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
